mips_instr_encoder: RTL and testbench

//  Encodes symbolic instruction requests (kind + fields) into 32-bit MIPS words and streams

---
 rtl/mips_instr_encoder_if.sv | 25 ++
 rtl/mips_instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_encoder_if.sv
// Request channel into the MIPS instruction encoder: one symbolic instruction per
// valid/ready handshake, plus the end-of-program marker.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, in_last,
    output in_ready
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and streams them into
// instruction memory at sequential addresses, holding the CPU off until the load completes.
module mips_instr_encoder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  mips_instr_encoder_if.slave       req,
  output logic                      imem_we,
  output logic [AW-1:0]             imem_addr,
  output logic [31:0]               imem_wd,
  output logic [AW:0]               count,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_LW   = 3'd1;
  localparam logic [2:0] K_SW   = 3'd2;
  localparam logic [2:0] K_BEQ  = 3'd3;
  localparam logic [2:0] K_ADDI = 3'd4;
  localparam logic [2:0] K_J    = 3'd5;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_d;
  logic [CW-1:0]   count_d;
  logic            we_d;
  logic [AW-1:0]   addr_d;
  logic [31:0]     wd_d;
  logic            ready_d;
  logic            hold_d;
  logic            done_d;
  logic            err_d;
  logic            accept_c;
  logic            legal_c;
  logic [31:0]     word_c;

  // Field packing for the supported opcode set; fields unused by a kind are dropped.
  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      K_R:     w = {OP_R, rs, rt, rd, shamt, funct};
      K_LW:    w = {OP_LW, rs, rt, imm};
      K_SW:    w = {OP_SW, rs, rt, imm};
      K_BEQ:   w = {OP_BEQ, rs, rt, imm};
      K_ADDI:  w = {OP_ADDI, rs, rt, imm};
      K_J:     w = {OP_J, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign legal_c  = (req.in_kind <= K_J);
  assign accept_c = (state_q == S_LOAD) && req.in_valid && req.in_ready;
  assign word_c   = encode(req.in_kind, req.in_rs, req.in_rt, req.in_rd, req.in_shamt,
                           req.in_funct, req.in_imm, req.in_target);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A final word with in_last set completes the load even if it
  // lands on the last memory slot; otherwise filling the last slot is an overflow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept_c) begin
          if (!legal_c)                 state_d = S_ERR;
          else if (req.in_last)         state_d = S_DONE;
          else if (count == LAST_C)     state_d = S_ERR;
        end
      end
      S_DONE: begin
        if (start) state_d = S_LOAD;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything lands in registers below.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wd_d    = imem_wd;
    ptr_d   = ptr_q;
    count_d = count;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ptr_d   = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (accept_c && legal_c) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wd_d    = word_c;
          ptr_d   = ptr_q + AW'(1);
          count_d = count + CW'(1);
        end
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
    ready_d = (state_d == S_LOAD) && (count_d < DEPTH_C);
    done_d  = (state_d == S_DONE);
    hold_d  = (state_d != S_DONE);
    err_d   = (state_d == S_ERR);
  end

  // Registered outputs; reset wins over an accept on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q        <= '0;
      count        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wd      <= '0;
      req.in_ready <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      count        <= count_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wd      <= wd_d;
      req.in_ready <= ready_d;
      cpu_hold     <= hold_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed spec vectors plus randomized programs
// checked against an arithmetic reference encoder.
module tb_mips_instr_encoder;

  typedef struct packed {
    logic [2:0]  k;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
  } req_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wd;
  logic [6:0]  count;
  logic        cpu_hold;
  logic        done;
  logic        err;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_wr_cyc = -10;
  int   wr_gap = 0;
  int   model_ptr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mips_instr_encoder_if bus ();

  mips_instr_encoder #(.DEPTH(64), .AW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .req       (bus),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .count     (count),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference encoder: fields weighted by their bit position, opcode from a table.
  function automatic logic [31:0] ref_word(input req_t r);
    int     op_tab[6] = '{0, 35, 43, 4, 8, 2};
    longint w;
    longint op;
    op = longint'(op_tab[int'(r.k)]) * 67108864;
    if (r.k == 3'd0)
      w = longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048 +
          longint'(r.sh) * 64 + longint'(r.fn);
    else if (r.k == 3'd5)
      w = op + longint'(r.tgt);
    else
      w = op + longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.imm);
    return 32'(w);
  endfunction

  function automatic req_t rnd_req(input logic [2:0] k, input logic last);
    req_t r;
    r.k    = k;
    r.rs   = 5'($urandom);
    r.rt   = 5'($urandom);
    r.rd   = 5'($urandom);
    r.sh   = 5'($urandom);
    r.fn   = 6'($urandom);
    r.imm  = 16'($urandom);
    r.tgt  = 26'($urandom);
    r.last = last;
    return r;
  endfunction

  function automatic req_t mk(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] fn,
                              input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    req_t r;
    r.k = k; r.rs = rs; r.rt = rt; r.rd = rd; r.sh = 5'd0; r.fn = fn;
    r.imm = imm; r.tgt = tgt; r.last = last;
    return r;
  endfunction

  // Present one request; on accept, queue the expected write (legal kinds only).
  task automatic send(input req_t r, input bit has_exp, input logic [31:0] exp_w,
                      input int budget, output bit acc);
    exp_t e;
    int   n = 0;
    bus.in_valid  = 1'b1;
    bus.in_kind   = r.k;
    bus.in_rs     = r.rs;
    bus.in_rt     = r.rt;
    bus.in_rd     = r.rd;
    bus.in_shamt  = r.sh;
    bus.in_funct  = r.fn;
    bus.in_imm    = r.imm;
    bus.in_target = r.tgt;
    bus.in_last   = r.last;
    acc = 1'b0;
    while (!acc && n < budget) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) acc = 1'b1;
      else n++;
    end
    if (acc) begin
      @(posedge clk);
      if (r.k <= 3'd5) begin
        e.addr = 6'(model_ptr);
        e.word = has_exp ? exp_w : ref_word(r);
        sb.push_back(e);
        model_ptr++;
      end
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic put(input req_t r, input bit has_exp, input logic [31:0] exp_w);
    bit acc;
    send(r, has_exp, exp_w, 200, acc);
    chk("accept_within_budget", 32'(acc), 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_ptr = 0;
  endtask

  // Monitor: every imem write must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
          chk("wr_word", imem_wd, mon_e.word);
        end
        wr_gap = cyc - last_wr_cyc;
        last_wr_cyc = cyc;
      end
    end
  end

  initial begin
    bit   acc;
    int   n;
    req_t r;
    bus.in_valid = 1'b0;
    bus.in_kind = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_shamt = '0;
    bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0; bus.in_last = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wd", imem_wd, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(bus.in_ready), 32'd0);

    // T1: single R-type program
    do_start();
    chk("load_ready", 32'(bus.in_ready), 32'd1);
    chk("load_hold", 32'(cpu_hold), 32'd1);
    put(mk(3'd0, 5'd17, 5'd18, 5'd16, 6'h20, 16'h0, 26'h0, 1'b1), 1'b1, 32'h02328020);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(count), 32'd1);

    // T2/T3: back-to-back LW, SW then BEQ, ADDI, J(last)
    do_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    put(mk(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0050, 26'h0, 1'b0), 1'b1, 32'h8C020050);
    put(mk(3'd2, 5'd29, 5'd31, 5'd0, 6'd0, 16'h0004, 26'h0, 1'b0), 1'b1, 32'hAFBF0004);
    @(posedge clk);
    #1;
    chk("t2_b2b_gap", 32'(wr_gap), 32'd1);
    chk("t2_count", 32'(count), 32'd2);
    put(mk(3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFE, 26'h0, 1'b0), 1'b1, 32'h1085FFFE);
    put(mk(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'h0, 1'b0), 1'b1, 32'h20080005);
    put(mk(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h11, 1'b1), 1'b1, 32'h08000011);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_hold", 32'(cpu_hold), 32'd0);
    chk("t3_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t3_count", 32'(count), 32'd5);

    // Randomized programs with idle gaps between requests
    for (int round = 0; round < 4; round++) begin
      do_start();
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        put(rnd_req(3'($urandom_range(0, 5)), 1'(i == n - 1)), 1'b0, 32'd0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
      chk("rnd_done", 32'(done), 32'd1);
      chk("rnd_count", 32'(count), 32'(n));
      chk("rnd_hold", 32'(cpu_hold), 32'd0);
    end

    // T4: illegal kind mid-stream
    do_start();
    for (int i = 0; i < 3; i++) put(rnd_req(3'($urandom_range(0, 5)), 1'b0), 1'b0, 32'd0);
    put(rnd_req(3'd6, 1'b0), 1'b0, 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_ready", 32'(bus.in_ready), 32'd0);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_count", 32'(count), 32'd3);
    do_start();
    @(posedge clk);
    #1;
    chk("t4_start_ignored_err", 32'(err), 32'd1);
    chk("t4_start_ignored_ready", 32'(bus.in_ready), 32'd0);
    chk("t4_start_ignored_count", 32'(count), 32'd3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t4_reset_err", 32'(err), 32'd0);
    chk("t4_reset_count", 32'(count), 32'd0);

    // T5: overflow after filling all 64 slots
    do_start();
    for (int i = 0; i < 64; i++) put(rnd_req(3'($urandom_range(0, 5)), 1'b0), 1'b0, 32'd0);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_count", 32'(count), 32'd64);
    send(rnd_req(3'd0, 1'b0), 1'b0, 32'd0, 8, acc);
    chk("t5_no_65th", 32'(acc), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // T6: reset on the accept edge of the third word
    do_start();
    for (int i = 0; i < 2; i++) put(rnd_req(3'($urandom_range(0, 5)), 1'b0), 1'b0, 32'd0);
    r = rnd_req(3'd0, 1'b0);
    bus.in_kind = r.k; bus.in_rs = r.rs; bus.in_rt = r.rt; bus.in_rd = r.rd;
    bus.in_shamt = r.sh; bus.in_funct = r.fn; bus.in_imm = r.imm; bus.in_target = r.tgt;
    bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_idle_ready", 32'(bus.in_ready), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
